// File: rtl/elm_neuron_mac.sv
// Hidden-layer neuron MAC: streams inputs against a 1-cycle weight memory, accumulates, adds bias, saturates out.
// Optional build macro ACC_SAT_EN: accumulator saturates on signed overflow instead of wrapping.
module elm_neuron_mac #(
    parameter int numWeight    = 784,
    parameter int addressWidth = 10,
    parameter int dataWidth    = 16,
    parameter int fracBits     = 8,
    parameter int layerNo      = 1,
    parameter int neuronNo     = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [dataWidth-1:0]    myinput,
    input  logic                    myinputValid,
    input  logic [dataWidth-1:0]    bias,
    output logic                    ren,
    output logic [addressWidth:0]   raddr,
    input  logic [dataWidth-1:0]    wout,
    output logic [dataWidth-1:0]    out,
    output logic                    outvalid,
    output logic                    busy
);

    localparam int RW = addressWidth + 1;
    localparam int PW = 2 * dataWidth;
    localparam int AW = 2 * dataWidth + 8;
    localparam int SW = AW + 1;
    localparam logic [RW-1:0] LAST_IDX = RW'(numWeight - 1);
    localparam logic signed [SW-1:0] OUT_MAX = {{(SW-dataWidth+1){1'b0}}, {(dataWidth-1){1'b1}}};
    localparam logic signed [SW-1:0] OUT_MIN = {{(SW-dataWidth+1){1'b1}}, {(dataWidth-1){1'b0}}};

    if (numWeight < 1 || numWeight > 2**RW || layerNo < 0 || neuronNo < 0) begin : g_param_check
        $error("elm_neuron_mac: illegal parameter set");
    end

    typedef enum logic [1:0] {IDLE, ACC, BIAS, OUT} state_t;

    state_t                 state_q, state_d;
    logic [RW-1:0]          wcnt;
    logic signed [dataWidth-1:0] in_d;
    logic                   v1, last1, first1;
    logic                   v2, last2, first2;
    logic signed [PW-1:0]   mul;
    logic signed [AW-1:0]   acc, acc_nxt, acc_sum, mul_ext;
    logic signed [SW-1:0]   bias_ext, sum, shifted;
    logic [dataWidth-1:0]   sat_val;
`ifdef ACC_SAT_EN
    logic signed [AW:0]     wide;
`endif

    assign ren   = myinputValid;
    assign raddr = wcnt;
    assign busy  = (state_q != IDLE) | v1 | v2 | outvalid;

    always_comb begin
        mul_ext = {{(AW-PW){mul[PW-1]}}, mul};
`ifdef ACC_SAT_EN
        wide = {acc[AW-1], acc} + {{(AW-PW+1){mul[PW-1]}}, mul};
        if (wide[AW] != wide[AW-1])
            acc_sum = wide[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
        else
            acc_sum = wide[AW-1:0];
`else
        acc_sum = acc + mul_ext;
`endif
        acc_nxt = first2 ? mul_ext : acc_sum;
    end

    // Bias path reads acc before the next vector's first product reloads it, so the two overlap.
    always_comb begin
        bias_ext = {{(SW-dataWidth){bias[dataWidth-1]}}, bias};
        sum      = {acc[AW-1], acc} + (bias_ext <<< fracBits);
        shifted  = sum >>> fracBits;
        if (shifted > OUT_MAX)
            sat_val = OUT_MAX[dataWidth-1:0];
        else if (shifted < OUT_MIN)
            sat_val = OUT_MIN[dataWidth-1:0];
        else
            sat_val = shifted[dataWidth-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wcnt     <= '0;
            in_d     <= '0;
            v1       <= 1'b0;
            last1    <= 1'b0;
            first1   <= 1'b0;
            v2       <= 1'b0;
            last2    <= 1'b0;
            first2   <= 1'b0;
            mul      <= '0;
            acc      <= '0;
            out      <= '0;
            outvalid <= 1'b0;
        end else begin
            v1 <= myinputValid;
            if (myinputValid) begin
                in_d   <= myinput;
                last1  <= (wcnt == LAST_IDX);
                first1 <= (wcnt == '0);
                wcnt   <= (wcnt == LAST_IDX) ? '0 : wcnt + 1'b1;
            end
            v2     <= v1;
            last2  <= last1;
            first2 <= first1;
            if (v1)
                mul <= in_d * $signed(wout);
            if (v2)
                acc <= acc_nxt;
            outvalid <= (state_q == BIAS);
            if (state_q == BIAS)
                out <= sat_val;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // A completed vector forces BIAS from any state, so single-element back-to-back vectors still drain.
    always_comb begin
        state_d = state_q;
        if (v2 && last2) begin
            state_d = BIAS;
        end else begin
            unique case (state_q)
                IDLE: if (myinputValid) state_d = ACC;
                ACC:  state_d = ACC;
                BIAS: state_d = OUT;
                OUT:  state_d = (myinputValid | v1 | v2 | (wcnt != '0)) ? ACC : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_elm_neuron_mac.sv
// Self-checking bench for elm_neuron_mac: three instances (4, 600 and 1 weights) against a queue-based reference model.
module tb_elm_neuron_mac;

    localparam longint ACC_MAX = 64'sd549755813887;
    localparam longint ACC_MIN = -64'sd549755813888;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [15:0] myinput = '0;
    logic signed [15:0] bias = '0;
    logic               valid [3] = '{1'b0, 1'b0, 1'b0};
    logic               ren [3];
    logic [10:0]        raddr [3];
    logic [15:0]        wout [3];
    logic [15:0]        out [3];
    logic               outvalid [3];
    logic               busy [3];

    logic [15:0]        wmem [3][600];
    int unsigned        nw [3] = '{4, 600, 1};
    int unsigned        cnt [3];
    longint             acc_m [3];
    longint             last_out [3];
    longint             prev_out [3];
    int                 last_ov [3];
    int                 prev_ov [3];
    int                 cyc = 0;
    int                 checks = 0;
    int                 errors = 0;

    typedef struct { int inst; longint acc; int t; } pend_t;
    typedef struct { int inst; longint val; int due; } exp_t;
    pend_t pend_q [$];
    exp_t  exp_q [$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 3; i++)
            if (ren[i]) wout[i] <= wmem[i][int'(raddr[i]) % 600];
    end

    elm_neuron_mac #(.numWeight(4), .addressWidth(10), .dataWidth(16), .fracBits(8),
                     .layerNo(1), .neuronNo(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .myinput(myinput), .myinputValid(valid[0]), .bias(bias),
        .ren(ren[0]), .raddr(raddr[0]), .wout(wout[0]), .out(out[0]), .outvalid(outvalid[0]),
        .busy(busy[0]));

    elm_neuron_mac #(.numWeight(600), .addressWidth(10), .dataWidth(16), .fracBits(8),
                     .layerNo(1), .neuronNo(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .myinput(myinput), .myinputValid(valid[1]), .bias(bias),
        .ren(ren[1]), .raddr(raddr[1]), .wout(wout[1]), .out(out[1]), .outvalid(outvalid[1]),
        .busy(busy[1]));

    elm_neuron_mac #(.numWeight(1), .addressWidth(10), .dataWidth(16), .fracBits(8),
                     .layerNo(1), .neuronNo(2)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .myinput(myinput), .myinputValid(valid[2]), .bias(bias),
        .ren(ren[2]), .raddr(raddr[2]), .wout(wout[2]), .out(out[2]), .outvalid(outvalid[2]),
        .busy(busy[2]));

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic longint acc_add(input longint a, input longint p);
        longint r;
        r = a + p;
`ifdef ACC_SAT_EN
        if (r > ACC_MAX) r = ACC_MAX;
        else if (r < ACC_MIN) r = ACC_MIN;
`else
        r = (r <<< 24) >>> 24;
`endif
        return r;
    endfunction

    function automatic longint final_out(input longint a, input longint b);
        longint s;
        s = (a + (b <<< 8)) >>> 8;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int i, input logic [15:0] x, input logic [15:0] w);
        myinput = x;
        wmem[i][cnt[i]] = w;
        valid[i] = 1'b1;
        tick();
        valid[i] = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Reference model and output monitor
    initial begin
        longint prod;
        int     idx;
        pend_t  p;
        exp_t   x;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                for (int i = 0; i < 3; i++) begin
                    cnt[i] = 0;
                    acc_m[i] = 0;
                end
                pend_q.delete();
                exp_q.delete();
            end else begin
                for (int i = 0; i < 3; i++) begin
                    chk($sformatf("raddr%0d", i), longint'(raddr[i]), longint'(cnt[i]));
                    chk($sformatf("ren%0d", i), longint'(ren[i]), longint'(valid[i]));
                    if (valid[i]) begin
                        prod = longint'(myinput) * longint'($signed(wmem[i][cnt[i]]));
                        acc_m[i] = (cnt[i] == 0) ? prod : acc_add(acc_m[i], prod);
                        if (cnt[i] == nw[i] - 1) begin
                            p.inst = i;
                            p.acc = acc_m[i];
                            p.t = cyc;
                            pend_q.push_back(p);
                            cnt[i] = 0;
                        end else begin
                            cnt[i]++;
                        end
                    end
                end
                while (pend_q.size() > 0 && pend_q[0].t + 3 <= cyc) begin
                    x.inst = pend_q[0].inst;
                    x.val = final_out(pend_q[0].acc, longint'(bias));
                    x.due = pend_q[0].t + 4;
                    exp_q.push_back(x);
                    void'(pend_q.pop_front());
                end
                for (int i = 0; i < 3; i++) begin
                    idx = -1;
                    for (int k = 0; k < exp_q.size(); k++)
                        if (idx < 0 && exp_q[k].inst == i) idx = k;
                    if (outvalid[i]) begin
                        if (idx < 0) begin
                            chk($sformatf("spurious_outvalid%0d", i), 1, 0);
                        end else begin
                            chk($sformatf("out%0d", i), longint'($signed(out[i])), exp_q[idx].val);
                            chk($sformatf("latency%0d", i), longint'(cyc), longint'(exp_q[idx].due));
                            exp_q.delete(idx);
                        end
                        prev_out[i] = last_out[i];
                        last_out[i] = longint'($signed(out[i]));
                        prev_ov[i] = last_ov[i];
                        last_ov[i] = cyc;
                    end else if (idx >= 0 && exp_q[idx].due < cyc) begin
                        chk($sformatf("missing_outvalid%0d", i), 0, 1);
                        exp_q.delete(idx);
                    end
                end
            end
        end
    end

    initial begin
        longint exp_b;
        repeat (3) tick();
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_out%0d", i), longint'(out[i]), 0);
            chk($sformatf("rst_outvalid%0d", i), longint'(outvalid[i]), 0);
            chk($sformatf("rst_busy%0d", i), longint'(busy[i]), 0);
            chk($sformatf("rst_raddr%0d", i), longint'(raddr[i]), 0);
        end
        tick();

        // Basic vector, no gaps
        bias = 16'sh0080;
        for (int e = 0; e < 4; e++) send(0, 16'((e + 1) * 256), 16'h0100);
        @(negedge clk);
        chk("t1_busy", longint'(busy[0]), 1);
        repeat (7) tick();
        @(negedge clk);
        chk("t1_out", last_out[0], 64'sh0A80);
        chk("t1_idle", longint'(busy[0]), 0);
        tick();

        // Same vector with 2-cycle gaps
        for (int e = 0; e < 4; e++) begin
            send(0, 16'((e + 1) * 256), 16'h0100);
            repeat (2) tick();
        end
        repeat (6) tick();
        @(negedge clk);
        chk("t2_out", last_out[0], 64'sh0A80);
        tick();

        // Back-to-back vectors; second has zero weights and bias
        for (int e = 0; e < 4; e++) send(0, 16'((e + 1) * 256), 16'h0100);
        for (int e = 0; e < 4; e++) send(0, 16'($urandom), 16'h0000);
        bias = 16'sh0000;
        repeat (8) tick();
        @(negedge clk);
        chk("t3_first", prev_out[0], 64'sh0A80);
        chk("t3_second", last_out[0], 0);
        chk("t3_spacing", longint'(last_ov[0] - prev_ov[0]), 4);
        tick();

        // Output saturation, and accumulator overflow on a long vector
        for (int e = 0; e < 4; e++) send(0, 16'h7FFF, 16'h7FFF);
        repeat (8) tick();
        @(negedge clk);
        chk("t4_outsat", last_out[0], 32767);
        tick();
        for (int e = 0; e < 600; e++) send(1, 16'h7FFF, 16'h7FFF);
        repeat (8) tick();
`ifdef ACC_SAT_EN
        exp_b = 32767;
`else
        exp_b = -32768;
`endif
        @(negedge clk);
        chk("t4_accovf", last_out[1], exp_b);
        tick();

        // Reset mid-vector, then a fresh vector
        bias = 16'sh0080;
        send(0, 16'h0100, 16'h0100);
        send(0, 16'h0200, 16'h0100);
        do_reset();
        @(negedge clk);
        chk("t5_raddr", longint'(raddr[0]), 0);
        chk("t5_busy", longint'(busy[0]), 0);
        tick();
        for (int e = 0; e < 4; e++) send(0, 16'((e + 1) * 256), 16'h0100);
        repeat (8) tick();
        @(negedge clk);
        chk("t5_out", last_out[0], 64'sh0A80);
        tick();

        // Randomized vectors with random gaps
        for (int v = 0; v < 20; v++) begin
            bias = 16'($urandom);
            for (int e = 0; e < 4; e++) begin
                send(0, 16'($urandom), 16'($urandom));
                repeat ($urandom_range(0, 2)) tick();
            end
            repeat (5) tick();
        end

        // Single-weight neuron: every input is a complete vector
        bias = 16'($urandom);
        for (int e = 0; e < 12; e++) send(2, 16'($urandom), 16'($urandom));
        for (int e = 0; e < 6; e++) begin
            send(2, 16'($urandom), 16'($urandom));
            repeat ($urandom_range(0, 2)) tick();
        end
        repeat (8) tick();

        // Long random vector
        bias = 16'($urandom);
        for (int e = 0; e < 600; e++) send(1, 16'($urandom), 16'($urandom));
        repeat (8) tick();

        @(negedge clk);
        chk("end_pending", longint'(exp_q.size() + pend_q.size()), 0);
        for (int i = 0; i < 3; i++)
            chk($sformatf("end_busy%0d", i), longint'(busy[i]), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
